hamming_secded_pipe: RTL

HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

---
 rtl/hamming_pkg.sv | 52 +++++
 rtl/hamming_enc.sv | 33 +++
 rtl/hamming_secded_pipe.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// hamming_pkg : shared SECDED geometry and codeword helper functions
// Revision: 1.0
// ============================================================================
package hamming_pkg;

  localparam int MAX_CODE_W = 64;
  localparam int MAX_PAR_W  = 7;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_par_w(input int data_w);
    int r;
    r = 0;
    for (int k = MAX_PAR_W; k >= 1; k--) begin
      if ((1 << k) >= data_w + k + 1) r = k;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position of data bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < MAX_CODE_W; p++) begin
      if (!is_pow2(p) && (pos == 0)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // XOR of the Hamming positions 1..code_w-1 whose bit is set.
  function automatic logic [MAX_PAR_W-1:0] syndrome(input logic [MAX_CODE_W-1:0] code,
                                                    input int code_w);
    logic [MAX_PAR_W-1:0] s;
    s = '0;
    for (int p = 1; p < MAX_CODE_W; p++) begin
      if ((p < code_w) && code[p]) s ^= MAX_PAR_W'(p);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_enc.sv
`default_nettype none
// ============================================================================
// hamming_enc : combinational SECDED encoder (data -> extended Hamming code)
// Revision: 1.0
// ============================================================================
module hamming_enc
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 8,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code
);

  logic [CODE_W-1:0] w_code;
  logic [PAR_W-1:0]  w_syn;

  // Parity bits equal the syndrome of the data-only word, which zeroes the
  // syndrome of the full codeword.
  always_comb begin
    w_code = '0;
    for (int i = 0; i < DATA_W; i++) w_code[data_pos(i)] = i_data[i];
    w_syn = PAR_W'(syndrome(MAX_CODE_W'(w_code), CODE_W));
    for (int k = 0; k < PAR_W; k++) w_code[1 << k] = w_syn[k];
    w_code[0] = ^w_code[CODE_W-1:1];
  end

  assign o_code = w_code;

endmodule
`default_nettype wire

// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
// hamming_secded_pipe : 3-stage SECDED encode/check/correct pipeline with
// saturating error counters; HAMMING_ERR_INJECT_EN adds the inj_mask port.
// Revision: 1.0
// ============================================================================
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int  DATA_W  = 8,
  parameter int  COUNT_W = 8,
  localparam int PAR_W   = calc_par_w(DATA_W),
  localparam int CODE_W  = DATA_W + PAR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [CODE_W-1:0]  inj_mask,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sgl,
  output logic               out_dbl,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] cnt_corr,
  output logic [COUNT_W-1:0] cnt_unc
);

  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [CODE_W-1:0]  code1_q, code1_d, code2_q, code2_d;
  logic [PAR_W-1:0]   syn2_q, syn2_d;
  logic               par_bad2_q, par_bad2_d;
  logic [DATA_W-1:0]  data3_q, data3_d;
  logic               sgl3_q, sgl3_d, dbl3_q, dbl3_d;
  logic [COUNT_W-1:0] cnt_corr_q, cnt_corr_d, cnt_unc_q, cnt_unc_d;

  logic [CODE_W-1:0]  w_enc, w_mask, w_fixed;
  logic [DATA_W-1:0]  w_dec;
  logic               w_sgl, w_dbl;
  logic               w_s3_free, w_s2_free, w_accept, w_out_hs;

  hamming_enc #(.DATA_W(DATA_W)) u_enc (
    .i_data (in_data),
    .o_code (w_enc)
  );

`ifdef HAMMING_ERR_INJECT_EN
  assign w_mask = inj_mask;
`else
  assign w_mask = '0;
`endif

  // A stage can take new contents when empty or when its word moves on.
  always_comb begin
    w_s3_free = !v3_q || out_ready;
    w_s2_free = !v2_q || w_s3_free;
    in_ready  = !v1_q || w_s2_free;
    w_accept  = in_valid && in_ready;
    w_out_hs  = v3_q && out_ready;
  end

  always_comb begin
    w_fixed = code2_q;
    w_sgl   = 1'b0;
    w_dbl   = 1'b0;
    if (syn2_q == '0) begin
      w_sgl = par_bad2_q;
    end else if (par_bad2_q && (32'(syn2_q) < CODE_W)) begin
      w_fixed[syn2_q] = ~w_fixed[syn2_q];
      w_sgl           = 1'b1;
    end else begin
      w_dbl = 1'b1;
    end
    for (int i = 0; i < DATA_W; i++) w_dec[i] = w_fixed[data_pos(i)];
  end

  always_comb begin
    v1_d       = v1_q;
    v2_d       = v2_q;
    v3_d       = v3_q;
    code1_d    = code1_q;
    code2_d    = code2_q;
    syn2_d     = syn2_q;
    par_bad2_d = par_bad2_q;
    data3_d    = data3_q;
    sgl3_d     = sgl3_q;
    dbl3_d     = dbl3_q;
    cnt_corr_d = cnt_corr_q;
    cnt_unc_d  = cnt_unc_q;

    if (in_ready) v1_d = in_valid;
    if (w_accept) code1_d = w_enc ^ w_mask;

    if (w_s2_free) v2_d = v1_q;
    if (w_s2_free && v1_q) begin
      syn2_d     = PAR_W'(syndrome(MAX_CODE_W'(code1_q), CODE_W));
      par_bad2_d = ^code1_q;
      code2_d    = code1_q;
    end

    if (w_s3_free) v3_d = v2_q;
    if (w_s3_free && v2_q) begin
      data3_d = w_dec;
      sgl3_d  = w_sgl;
      dbl3_d  = w_dbl;
    end

    // Clear wins over a same-cycle increment.
    if (cnt_clr) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
    end else if (w_out_hs) begin
      if (sgl3_q && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + COUNT_W'(1);
      if (dbl3_q && (cnt_unc_q != '1))  cnt_unc_d  = cnt_unc_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      code1_q    <= '0;
      code2_q    <= '0;
      syn2_q     <= '0;
      par_bad2_q <= 1'b0;
      data3_q    <= '0;
      sgl3_q     <= 1'b0;
      dbl3_q     <= 1'b0;
      cnt_corr_q <= '0;
      cnt_unc_q  <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      code1_q    <= code1_d;
      code2_q    <= code2_d;
      syn2_q     <= syn2_d;
      par_bad2_q <= par_bad2_d;
      data3_q    <= data3_d;
      sgl3_q     <= sgl3_d;
      dbl3_q     <= dbl3_d;
      cnt_corr_q <= cnt_corr_d;
      cnt_unc_q  <= cnt_unc_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = data3_q;
  assign out_sgl   = sgl3_q;
  assign out_dbl   = dbl3_q;
  assign cnt_corr  = cnt_corr_q;
  assign cnt_unc   = cnt_unc_q;

endmodule
`default_nettype wire
